// File: rtl/sram_write_sequencer.sv
// sram_write_sequencer: masked SRAM column write driver sequencing precharge, word-line and bit-line drive
module sram_write_sequencer #(
    parameter int COLS    = 8,
    parameter int GRAN    = 4,
    parameter int PRE_CYC = 2,
    parameter int WR_CYC  = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 wr_valid,
    output logic                 wr_ready,
    input  logic [COLS-1:0]      wr_data,
    input  logic [COLS/GRAN-1:0] wr_mask,
    output logic                 pre_en,
    output logic                 wl_en,
    output logic [COLS-1:0]      bl_wr,
    output logic [COLS-1:0]      blb_wr,
    output logic                 wr_done,
    output logic                 busy
);
    localparam int G  = COLS / GRAN;
    localparam int CW = $clog2((PRE_CYC > WR_CYC ? PRE_CYC : WR_CYC) + 1);

    if (COLS % GRAN != 0 || PRE_CYC < 1 || WR_CYC < 1) begin : g_bad_params
        $error("sram_write_sequencer: COLS must be a multiple of GRAN and cycle counts must be >= 1");
    end

    typedef enum logic [1:0] {IDLE, PRE, DRIVE, REC} state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [COLS-1:0] d;
    logic [G-1:0]    m;
    logic            drv;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            d     <= '1;
            m     <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            if (state == IDLE && wr_valid) begin
                d <= wr_data;
                m <= wr_mask;
            end
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        case (state)
            IDLE: if (wr_valid) begin
                state_n = PRE;
                cnt_n   = CW'(PRE_CYC - 1);
            end
            PRE: if (cnt == '0) begin
                state_n = DRIVE;
                cnt_n   = CW'(WR_CYC - 1);
            end else cnt_n = cnt - 1'b1;
            DRIVE: if (cnt == '0) state_n = REC;
                   else cnt_n = cnt - 1'b1;
            default: state_n = IDLE;
        endcase
    end

    // REC keeps driving so the word line falls before the bit lines release
    always_comb begin
        wr_ready = state == IDLE;
        busy     = state != IDLE;
        pre_en   = state == PRE;
        wl_en    = state == DRIVE;
        wr_done  = state == REC;
        drv      = state == DRIVE || state == REC;
        bl_wr    = '1;
        blb_wr   = '1;
        for (int i = 0; i < COLS; i++) begin
            bl_wr[i]  = (drv && m[i/GRAN]) ? d[i]  : 1'b1;
            blb_wr[i] = (drv && m[i/GRAN]) ? ~d[i] : 1'b1;
        end
    end
endmodule

// File: tb/tb_sram_write_sequencer.sv
// tb_sram_write_sequencer: directed and randomized checks against a cycle-offset reference model
module tb_sram_write_sequencer;
    localparam int COLS = 8, GRAN = 4, P = 2, W = 3, G = COLS / GRAN;

    logic clk = 0, rst_n = 0, wr_valid = 0;
    logic [COLS-1:0] wr_data = '0;
    logic [G-1:0] wr_mask = '0;
    logic wr_ready, pre_en, wl_en, wr_done, busy;
    logic [COLS-1:0] bl_wr, blb_wr;

    int compared = 0, mismatched = 0;
    int t = 0, accepts = 0, aborted = 0, dut_done = 0;
    logic [COLS-1:0] md = '1;
    logic [G-1:0] mm = '0;
    logic live = 0;

    sram_write_sequencer #(.COLS(COLS), .GRAN(GRAN), .PRE_CYC(P), .WR_CYC(W)) dut (
        .clk(clk), .rst_n(rst_n), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_data(wr_data), .wr_mask(wr_mask), .pre_en(pre_en), .wl_en(wl_en),
        .bl_wr(bl_wr), .blb_wr(blb_wr), .wr_done(wr_done), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    // t counts cycles since acceptance: 1..P precharge, then W drive, then one recovery
    always @(posedge clk) begin
        live = 1;
        if (!rst_n) begin
            if (t >= 1 && t <= P + W) aborted++;
            t = 0;
        end else if (t == 0 && wr_valid) begin
            t = 1;
            md = wr_data;
            mm = wr_mask;
            accepts++;
        end else if (t != 0) t = (t == P + W + 1) ? 0 : t + 1;
    end

    always @(negedge clk) begin
        logic drv;
        logic [COLS-1:0] ebl, eblb;
        if (live) begin
            drv = t > P && t <= P + W + 1;
            for (int i = 0; i < COLS; i++) begin
                ebl[i]  = (drv && mm[i/GRAN]) ? md[i]  : 1'b1;
                eblb[i] = (drv && mm[i/GRAN]) ? ~md[i] : 1'b1;
            end
            chk("m_ready", wr_ready, t == 0);
            chk("m_busy", busy, t != 0);
            chk("m_pre", pre_en, t >= 1 && t <= P);
            chk("m_wl", wl_en, t > P && t <= P + W);
            chk("m_done", wr_done, t == P + W + 1);
            chk("m_bl", bl_wr, ebl);
            chk("m_blb", blb_wr, eblb);
            chk("inv_pre_wl", pre_en & wl_en, 0);
            chk("inv_bl_low", bl_wr | blb_wr, 8'hFF);
            if (wr_done) dut_done++;
        end
    end

    task automatic wait_ready;
        int n = 0;
        while (!wr_ready && n < 20) begin
            tick;
            n++;
        end
        chk("wait_ready", wr_ready, 1);
    endtask

    initial begin
        int n;
        tick;
        tick;
        chk("rst_ready", wr_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_outs", {pre_en, wl_en, wr_done}, 0);
        chk("rst_bl", bl_wr, 8'hFF);
        chk("rst_blb", blb_wr, 8'hFF);
        rst_n = 1;
        tick;
        chk("idle_ready", wr_ready, 1);

        wr_valid = 1; wr_data = 8'hA5; wr_mask = 2'b11;
        tick;
        wr_valid = 0; wr_data = 8'h00;
        for (int j = 1; j <= 7; j++) begin
            chk("full_pre", pre_en, j <= 2);
            chk("full_wl", wl_en, j >= 3 && j <= 5);
            chk("full_done", wr_done, j == 6);
            chk("full_ready", wr_ready, j == 7);
            chk("full_bl", bl_wr, (j >= 3 && j <= 6) ? 8'hA5 : 8'hFF);
            chk("full_blb", blb_wr, (j >= 3 && j <= 6) ? 8'h5A : 8'hFF);
            if (j < 7) tick;
        end

        wr_valid = 1; wr_data = 8'h3C; wr_mask = 2'b01;
        tick;
        wr_valid = 0;
        tick; tick; tick;
        chk("mask_wl", wl_en, 1);
        chk("mask_bl", bl_wr, 8'hFC);
        chk("mask_blb", blb_wr, 8'hF3);
        wait_ready;

        wr_valid = 1; wr_data = 8'h0F; wr_mask = 2'b11;
        tick;
        wr_data = 8'hF0;
        n = 0;
        while (!wr_ready && n < 20) begin
            if (wl_en) chk("b2b_hold", bl_wr, 8'h0F);
            tick;
            n++;
        end
        chk("b2b_gap", n + 1, P + W + 2);
        tick;
        wr_valid = 0;
        n = 0;
        while (!wl_en && n < 20) begin
            tick;
            n++;
        end
        chk("b2b_second_bl", bl_wr, 8'hF0);
        chk("b2b_second_blb", blb_wr, 8'h0F);
        wait_ready;

        wr_valid = 1; wr_data = 8'h55; wr_mask = 2'b11;
        tick;
        wr_valid = 0;
        tick; tick; tick;
        chk("mid_wl", wl_en, 1);
        rst_n = 0;
        tick;
        chk("mid_wl_low", wl_en, 0);
        chk("mid_bl", bl_wr, 8'hFF);
        chk("mid_blb", blb_wr, 8'hFF);
        chk("mid_ready", wr_ready, 1);
        chk("mid_done", wr_done, 0);
        rst_n = 1;
        tick;
        chk("mid_after_done", wr_done, 0);

        repeat (10000) begin
            wr_valid = $urandom_range(1, 0) == 1;
            wr_data = COLS'($urandom);
            wr_mask = G'($urandom);
            rst_n = $urandom_range(63, 0) != 0;
            tick;
        end
        wr_valid = 0;
        rst_n = 1;
        repeat (12) tick;
        #1;
        chk("done_count", dut_done, accepts - aborted);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
